// File: rtl/pc_unit_ras.sv
// Program-counter unit with a circular return-address stack.
// State updates on the falling clock edge; next address is selected from sequential, branch, jump or return.
module pc_unit_ras #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned INC          = 4,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             PCWre,
    input  logic [1:0]       PCSrc,
    input  logic [WIDTH-1:0] Imm,
    input  logic [WIDTH-1:0] JumpAddr,
    input  logic             Call,
    output logic [WIDTH-1:0] Addr,
    output logic [WIDTH-1:0] AddrPlus,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasOverflow,
    output logic             RasUnderflow,
    output logic             Misaligned
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_RETURN = 2'b11
    } src_e;

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] next_addr;
    logic             do_pop;
    logic             do_push;
    logic             ret_empty;
    src_e             src;

    assign src        = src_e'(PCSrc);
    assign AddrPlus   = Addr + WIDTH'(INC);
    assign RasEmpty   = (count == '0);
    assign RasFull    = (count == CNT_W'(RAS_DEPTH));
    assign Misaligned = (Addr[1:0] != 2'b00);

    assign do_pop    = (src == SRC_RETURN) && !RasEmpty;
    assign ret_empty = (src == SRC_RETURN) && RasEmpty;
    assign do_push   = Call;

    always_comb begin
        next_addr = AddrPlus;
        unique case (src)
            SRC_SEQ:    next_addr = AddrPlus;
            SRC_BRANCH: next_addr = AddrPlus + {Imm[WIDTH-3:0], 2'b00};
            SRC_JUMP:   next_addr = JumpAddr;
            SRC_RETURN: next_addr = RasEmpty ? AddrPlus : ras[top];
            default:    next_addr = AddrPlus;
        endcase
    end

    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
            Addr         <= RESET_VECTOR;
            top          <= '0;
            count        <= '0;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else if (PCWre) begin
            Addr <= next_addr;
            if (ret_empty)
                RasUnderflow <= 1'b1;
            // Pop+push in one update is a replace of the top entry: pointer and count stay put.
            if (do_push && !do_pop) begin
                top <= top + PTR_W'(1);
                if (RasFull)
                    RasOverflow <= 1'b1;
                else
                    count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                top   <= top - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

    // Stack contents need no reset; only pointer and count define validity.
    always_ff @(negedge CLK) begin
        if (PCWre && !Reset && do_push) begin
            if (do_pop)
                ras[top] <= AddrPlus;
            else
                ras[top + PTR_W'(1)] <= AddrPlus;
        end
    end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras with hand-computed expected addresses and flags.
module tb_pc_unit_ras;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] Imm;
    logic [31:0] JumpAddr;
    logic        Call;
    logic [31:0] Addr;
    logic [31:0] AddrPlus;
    logic        RasEmpty;
    logic        RasFull;
    logic        RasOverflow;
    logic        RasUnderflow;
    logic        Misaligned;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    pc_unit_ras #(
        .WIDTH(32),
        .RESET_VECTOR(32'h0),
        .INC(4),
        .RAS_DEPTH(4)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .PCWre(PCWre),
        .PCSrc(PCSrc),
        .Imm(Imm),
        .JumpAddr(JumpAddr),
        .Call(Call),
        .Addr(Addr),
        .AddrPlus(AddrPlus),
        .RasEmpty(RasEmpty),
        .RasFull(RasFull),
        .RasOverflow(RasOverflow),
        .RasUnderflow(RasUnderflow),
        .Misaligned(Misaligned)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive between edges, then sample just after the updating falling edge.
    task automatic apply(input logic we, input logic [1:0] src, input logic [31:0] imm,
                         input logic [31:0] jaddr, input logic call);
        @(posedge CLK);
        #1;
        PCWre    = we;
        PCSrc    = src;
        Imm      = imm;
        JumpAddr = jaddr;
        Call     = call;
        @(negedge CLK);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic emp, input logic full,
                               input logic ovf, input logic unf);
        check_eq({tag, "_empty"}, {31'b0, RasEmpty}, {31'b0, emp});
        check_eq({tag, "_full"},  {31'b0, RasFull},  {31'b0, full});
        check_eq({tag, "_ovf"},   {31'b0, RasOverflow},  {31'b0, ovf});
        check_eq({tag, "_unf"},   {31'b0, RasUnderflow}, {31'b0, unf});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        Reset = 1'b1; PCWre = 1'b0; PCSrc = 2'b00; Imm = '0; JumpAddr = '0; Call = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check_eq("reset_addr", Addr, 32'h0);
        check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        // Sequential fetch
        apply(1'b1, 2'b00, '0, '0, 1'b0); check_eq("seq1", Addr, 32'h4);
        apply(1'b1, 2'b00, '0, '0, 1'b0); check_eq("seq2", Addr, 32'h8);
        apply(1'b1, 2'b00, '0, '0, 1'b0); check_eq("seq3", Addr, 32'hC);
        check_eq("seq3_empty", {31'b0, RasEmpty}, 32'h1);

        // Backward branch and address wrap
        apply(1'b1, 2'b10, '0, 32'h10, 1'b0);         check_eq("jmp_10", Addr, 32'h10);
        apply(1'b1, 2'b01, 32'hFFFF_FFFE, '0, 1'b0);  check_eq("br_neg", Addr, 32'hC);
        apply(1'b1, 2'b01, 32'h3, '0, 1'b0);          check_eq("br_pos", Addr, 32'h1C);
        apply(1'b1, 2'b10, '0, 32'hFFFF_FFFC, 1'b0);  check_eq("addrplus_wrap", AddrPlus, 32'h0);
        apply(1'b1, 2'b00, '0, '0, 1'b0);             check_eq("seq_wrap", Addr, 32'h0);

        // Single call / return
        apply(1'b1, 2'b10, '0, 32'h20, 1'b0);
        apply(1'b1, 2'b10, '0, 32'h100, 1'b1);        check_eq("call_addr", Addr, 32'h100);
        check_flags("call1", 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 2'b11, '0, '0, 1'b0);             check_eq("ret_addr", Addr, 32'h24);
        check_eq("ret_empty", {31'b0, RasEmpty}, 32'h1);

        // Five nested calls into a four-deep stack
        apply(1'b1, 2'b10, '0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = Addr + 32'h40;
            apply(1'b1, 2'b10, '0, a, 1'b1);
            check_eq("nest_addr", Addr, a);
            if (i == 3) check_flags("nest4", 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check_flags("nest5", 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b1, 2'b11, '0, '0, 1'b0); check_eq("pop1", Addr, 32'h104);
        apply(1'b1, 2'b11, '0, '0, 1'b0); check_eq("pop2", Addr, 32'hC4);
        apply(1'b1, 2'b11, '0, '0, 1'b0); check_eq("pop3", Addr, 32'h84);
        apply(1'b1, 2'b11, '0, '0, 1'b0); check_eq("pop4", Addr, 32'h44);
        apply(1'b1, 2'b11, '0, '0, 1'b0); check_eq("pop5_underflow", Addr, 32'h48);
        check_flags("pop5", 1'b1, 1'b0, 1'b1, 1'b1);

        // Simultaneous pop and push, then hold
        apply(1'b1, 2'b10, '0, 32'h20, 1'b0);
        apply(1'b1, 2'b10, '0, 32'h200, 1'b1);        check_eq("setup_200", Addr, 32'h200);
        apply(1'b1, 2'b11, '0, '0, 1'b1);             check_eq("poppush_addr", Addr, 32'h24);
        check_flags("poppush", 1'b0, 1'b0, 1'b1, 1'b1);
        apply(1'b0, 2'b11, '0, '0, 1'b1);             check_eq("hold_addr", Addr, 32'h24);
        check_eq("hold_empty", {31'b0, RasEmpty}, 32'h0);
        apply(1'b0, 2'b10, '0, 32'h500, 1'b0);        check_eq("hold_jmp", Addr, 32'h24);
        apply(1'b1, 2'b11, '0, '0, 1'b0);             check_eq("ret_replaced", Addr, 32'h204);
        check_eq("ret_replaced_empty", {31'b0, RasEmpty}, 32'h1);

        // Asynchronous reset between edges in a call sequence
        apply(1'b1, 2'b10, '0, 32'h300, 1'b1);
        apply(1'b1, 2'b10, '0, 32'h340, 1'b1);        check_eq("pre_reset", Addr, 32'h340);
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("async_reset_addr", Addr, 32'h0);
        check_flags("async_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        Reset = 1'b0;
        apply(1'b1, 2'b10, '0, 32'h102, 1'b0);        check_eq("misalign_addr", Addr, 32'h102);
        check_eq("misaligned", {31'b0, Misaligned}, 32'h1);
        check_eq("misalign_plus", AddrPlus, 32'h106);
        apply(1'b1, 2'b10, '0, 32'h104, 1'b0);
        check_eq("aligned", {31'b0, Misaligned}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised program-counter unit for the multi-cycle CPU; successor to the single-register PC.
- Holds the current fetch address and computes the next address internally from a source select: sequential, branch-relative, jump-absolute or return.
- Contains a circular return-address stack (RAS) pushed on calls and popped on returns, with full/empty status and sticky error flags.
- Sits between the control unit (PCWre, PCSrc, Call) and instruction memory (Addr).

Parameters:
- WIDTH, 32, address width in bits (>= 8).
- RESET_VECTOR, 0, value loaded into Addr on reset; must be a multiple of INC.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; power of two, >= 2.

Ports:
- CLK  input  1  clock; all state updates on the falling edge.
- Reset  input  1  asynchronous, active-high reset.
- PCWre  input  1  1 = update PC/RAS this edge; 0 = hold everything.
- PCSrc  input  2  next-address select: 00 sequential, 01 branch, 10 jump, 11 return.
- Imm  input  WIDTH  sign-extended word offset for branch.
- JumpAddr  input  WIDTH  absolute target for jump.
- Call  input  1  push AddrPlus onto the RAS at this update.
- Addr  output  WIDTH  current PC (register).
- AddrPlus  output  WIDTH  combinational Addr + INC, modulo 2^WIDTH.
- RasEmpty  output  1  combinational; count == 0.
- RasFull  output  1  combinational; count == RAS_DEPTH.
- RasOverflow  output  1  sticky; a push occurred while full.
- RasUnderflow  output  1  sticky; a return occurred while empty.
- Misaligned  output  1  combinational; Addr[1:0] != 0.

Behaviour:
- Reset high, asynchronous, at any time (including mid-sequence):
  - Addr = RESET_VECTOR.
  - RAS top pointer = 0, count = 0.
  - RasOverflow = 0, RasUnderflow = 0.
  - RAS entry contents are don't-care.
- Reset released: on each falling CLK edge with PCWre = 1:
  - Addr <= next.
  - RAS and flags update as below.
- PCWre = 0: Addr, RAS, count and flags all hold; Call and PCSrc are ignored.
- next, all arithmetic modulo 2^WIDTH (wraps silently):
  - 00: AddrPlus.
  - 01: AddrPlus + (Imm << 2).
  - 10: JumpAddr, used unmodified. Misaligned flags an unaligned result; there is no trap.
  - 11: if count > 0, next = RAS[top]; else next = AddrPlus and RasUnderflow <= 1.
- Pop happens only when PCSrc = 11 and count > 0:
  - top decrements modulo RAS_DEPTH; count decrements.
- Push happens when Call = 1, independent of PCSrc:
  - Writes AddrPlus (the pre-update value) at top+1 modulo RAS_DEPTH; top increments.
  - count increments, saturating at RAS_DEPTH.
  - Push while full overwrites the oldest entry (circular) and sets RasOverflow <= 1. The new entry remains the top.
- Simultaneous pop and push (PCSrc = 11, Call = 1, count > 0):
  - next = old RAS[top].
  - RAS[top] is replaced by AddrPlus; top and count are unchanged; no overflow.
- Simultaneous push and return when empty:
  - next = AddrPlus; RasUnderflow <= 1.
  - Push proceeds, giving count = 1.
- Sticky flags clear only on Reset.
- Latency:
  - Addr reflects a new selection one falling edge after it is presented.
  - AddrPlus, RasEmpty, RasFull and Misaligned follow Addr and the count combinationally.

Test Plan:
- Reset (Reset = 1), then PCWre = 1, PCSrc = 00 for 3 falling edges -> Addr = 0, 4, 8, 0xC; RasEmpty = 1.
- At Addr = 0x10: branch Imm = -2 (0xFFFFFFFE) -> Addr = 0x0C; then Addr = 0xFFFFFFFC with PCSrc = 00 -> Addr wraps to 0x0.
- From Addr = 0x20: jump to 0x100 with Call = 1 -> Addr = 0x100, RAS top = 0x24. Then PCSrc = 11 -> Addr = 0x24, RasEmpty = 1.
- Five calls (depth 4) from Addr = 0x0, 0x40, 0x80, 0xC0, 0x100, each jumping +0x40 -> RasFull = 1, RasOverflow = 1. Then four returns -> 0x104, 0xC4, 0x84, 0x44; a fifth return -> AddrPlus, RasUnderflow = 1.
- With one entry 0x24 and Addr = 0x200: PCSrc = 11, Call = 1 -> Addr = 0x24, top = 0x204, count = 1. Repeat with PCWre = 0 -> no change.
- Assert Reset asynchronously between edges mid-call sequence -> Addr = RESET_VECTOR immediately, RasEmpty = 1, flags = 0. Jump to 0x102 -> Misaligned = 1.
